// File: rtl/two_bit_ctr.sv
// Two-bit saturating branch-direction counter. It computes the write-back state, the
// prediction and the mispredict flag, plus registered update bookkeeping and statistics.
module two_bit_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  input  logic             ctr,
  input  logic [1:0]       crnt_stt,
  output logic [1:0]       next_stt,
  output logic             pred_dir,
  output logic             mispredict,
  output logic [1:0]       next_stt_q,
  output logic             upd_valid_q,
  output logic [CNT_W-1:0] upd_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [1:0] STT_SNT = 2'b00;
  localparam logic [1:0] STT_WNT = 2'b01;
  localparam logic [1:0] STT_WT  = 2'b10;
  localparam logic [1:0] STT_ST  = 2'b11;

  // strobe is a one-way valid with no ready: every strobe cycle is consumed,
  // back-to-back included, and there is never a stall.
  always_comb begin
    next_stt = crnt_stt;
    if (strobe) begin
      if (ctr) begin
        case (crnt_stt)
          STT_SNT: next_stt = STT_WNT;
          STT_WNT: next_stt = STT_WT;
          default: next_stt = STT_ST;
        endcase
      end else begin
        case (crnt_stt)
          STT_ST:  next_stt = STT_WT;
          STT_WT:  next_stt = STT_WNT;
          default: next_stt = STT_SNT;
        endcase
      end
    end
  end

  assign pred_dir   = crnt_stt[1];
  assign mispredict = strobe & (crnt_stt[1] != ctr);

  logic upd_sat;
  logic miss_sat;
  assign upd_sat  = &upd_cnt;
  assign miss_sat = &miss_cnt;

  // Each mispredict is also a strobe, so miss_cnt can never overtake upd_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_stt_q  <= STT_SNT;
      upd_valid_q <= 1'b0;
      upd_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      upd_valid_q <= strobe;
      if (strobe) begin
        next_stt_q <= next_stt;
        if (!upd_sat) upd_cnt <= upd_cnt + 1'b1;
      end
      if (mispredict && !miss_sat) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_two_bit_ctr.sv
// Self-checking bench for two_bit_ctr: directed scenarios plus random traffic checked
// against an arithmetic reference model. A CNT_W=3 copy exercises counter saturation.
module tb_two_bit_ctr;

  logic        clk;
  logic        rst_n;
  logic        strobe;
  logic        ctr;
  logic [1:0]  crnt_stt;
  logic [1:0]  next_stt;
  logic        pred_dir;
  logic        mispredict;
  logic [1:0]  next_stt_q;
  logic        upd_valid_q;
  logic [15:0] upd_cnt;
  logic [15:0] miss_cnt;

  logic [1:0]  s_next_stt;
  logic        s_pred_dir;
  logic        s_mispredict;
  logic [1:0]  s_next_stt_q;
  logic        s_upd_valid_q;
  logic [2:0]  s_upd_cnt;
  logic [2:0]  s_miss_cnt;

  int n_tests;
  int n_fail;

  // reference model state
  int m_nq, m_vq, m_upd, m_miss, m_supd, m_smiss;

  two_bit_ctr #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .strobe(strobe), .ctr(ctr), .crnt_stt(crnt_stt),
    .next_stt(next_stt), .pred_dir(pred_dir), .mispredict(mispredict),
    .next_stt_q(next_stt_q), .upd_valid_q(upd_valid_q),
    .upd_cnt(upd_cnt), .miss_cnt(miss_cnt)
  );

  two_bit_ctr #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .strobe(strobe), .ctr(ctr), .crnt_stt(crnt_stt),
    .next_stt(s_next_stt), .pred_dir(s_pred_dir), .mispredict(s_mispredict),
    .next_stt_q(s_next_stt_q), .upd_valid_q(s_upd_valid_q),
    .upd_cnt(s_upd_cnt), .miss_cnt(s_miss_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- reference model ----
  function automatic int model_next(int s, int st, int c);
    int r;
    r = s;
    if (st != 0) begin
      if (c != 0) r = (s + 1 > 3) ? 3 : s + 1;
      else        r = (s - 1 < 0) ? 0 : s - 1;
    end
    return r;
  endfunction

  function automatic int model_miss(int s, int st, int c);
    return (st != 0 && ((s >= 2) ? 1 : 0) != c) ? 1 : 0;
  endfunction

  // advance one rising edge, updating the model with the inputs present at that edge
  task automatic tick();
    int s, st, c;
    s = crnt_stt; st = strobe; c = ctr;
    @(posedge clk);
    if (!rst_n) begin
      m_nq = 0; m_vq = 0; m_upd = 0; m_miss = 0; m_supd = 0; m_smiss = 0;
    end else begin
      m_vq = st;
      if (st != 0) begin
        m_nq = model_next(s, st, c);
        m_upd  = (m_upd  + 1 > 65535) ? 65535 : m_upd + 1;
        m_supd = (m_supd + 1 > 7)     ? 7     : m_supd + 1;
      end
      if (model_miss(s, st, c) != 0) begin
        m_miss  = (m_miss  + 1 > 65535) ? 65535 : m_miss + 1;
        m_smiss = (m_smiss + 1 > 7)     ? 7     : m_smiss + 1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic st, input logic c, input logic [1:0] s);
    strobe = st; ctr = c; crnt_stt = s;
    #1;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 2'b01);
    tick(); tick();
    n_tests++; if (next_stt_q !== 2'b00) begin n_fail++; $display("FAIL reset_next_stt_q got %b want 00", next_stt_q); end
    n_tests++; if (upd_valid_q !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid_q got %b want 0", upd_valid_q); end
    n_tests++; if (upd_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_upd_cnt got %0d want 0", upd_cnt); end
    n_tests++; if (miss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_miss_cnt got %0d want 0", miss_cnt); end
    n_tests++; if (next_stt !== 2'b10) begin n_fail++; $display("FAIL reset_comb_next got %b want 10", next_stt); end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'b00);
    tick();
  endtask

  task automatic test_saturation_walk();
    logic [1:0] up_seq [4];
    logic [1:0] dn_seq [4];
    logic [1:0] s;
    up_seq = '{2'b01, 2'b10, 2'b11, 2'b11};
    dn_seq = '{2'b10, 2'b01, 2'b00, 2'b00};
    s = 2'b00;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, s);
      n_tests++; if (next_stt !== up_seq[i]) begin n_fail++; $display("FAIL walk_up[%0d] got %b want %b", i, next_stt, up_seq[i]); end
      s = next_stt;
      tick();
      n_tests++; if (next_stt_q !== up_seq[i]) begin n_fail++; $display("FAIL walk_up_q[%0d] got %b want %b", i, next_stt_q, up_seq[i]); end
    end
    s = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, s);
      n_tests++; if (next_stt !== dn_seq[i]) begin n_fail++; $display("FAIL walk_dn[%0d] got %b want %b", i, next_stt, dn_seq[i]); end
      s = next_stt;
      tick();
      n_tests++; if (next_stt_q !== dn_seq[i]) begin n_fail++; $display("FAIL walk_dn_q[%0d] got %b want %b", i, next_stt_q, dn_seq[i]); end
    end
  endtask

  task automatic test_hold();
    for (int v = 0; v < 8; v++) begin
      drive(1'b0, v[0], v[2:1]);
      n_tests++; if (next_stt !== v[2:1]) begin n_fail++; $display("FAIL hold_next[%0d] got %b want %b", v, next_stt, v[2:1]); end
      n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL hold_miss[%0d] got %b want 0", v, mispredict); end
      tick();
      n_tests++; if (upd_valid_q !== 1'b0) begin n_fail++; $display("FAIL hold_valid[%0d] got %b want 0", v, upd_valid_q); end
      n_tests++; if (int'(upd_cnt) !== m_upd) begin n_fail++; $display("FAIL hold_upd_cnt[%0d] got %0d want %0d", v, upd_cnt, m_upd); end
    end
  endtask

  task automatic test_mispredict();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 2'b10);
    n_tests++; if (pred_dir !== 1'b1) begin n_fail++; $display("FAIL misp_pred got %b want 1", pred_dir); end
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL misp_flag got %b want 1", mispredict); end
    n_tests++; if (next_stt !== 2'b01) begin n_fail++; $display("FAIL misp_next got %b want 01", next_stt); end
    tick();
    n_tests++; if (next_stt_q !== 2'b01) begin n_fail++; $display("FAIL misp_next_q got %b want 01", next_stt_q); end
    n_tests++; if (upd_cnt !== 16'd1) begin n_fail++; $display("FAIL misp_upd_cnt got %0d want 1", upd_cnt); end
    n_tests++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL misp_miss_cnt got %0d want 1", miss_cnt); end
    n_tests++; if (upd_valid_q !== 1'b1) begin n_fail++; $display("FAIL misp_valid got %b want 1", upd_valid_q); end
    drive(1'b1, 1'b0, 2'b01);
    n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL misp_correct got %b want 0", mispredict); end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    logic [2:0] seq [5];
    // {ctr, crnt_stt}: two mispredicts then three correct predictions
    seq = '{3'b0_10, 3'b1_01, 3'b1_11, 3'b0_00, 3'b0_01};
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i][2], seq[i][1:0]);
      tick();
    end
    n_tests++; if (upd_cnt !== 16'd5) begin n_fail++; $display("FAIL mid_upd_cnt got %0d want 5", upd_cnt); end
    n_tests++; if (miss_cnt !== 16'd2) begin n_fail++; $display("FAIL mid_miss_cnt got %0d want 2", miss_cnt); end
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 2'b01);
    n_tests++; if (next_stt !== 2'b10) begin n_fail++; $display("FAIL mid_rst_comb got %b want 10", next_stt); end
    tick();
    n_tests++; if (next_stt_q !== 2'b00) begin n_fail++; $display("FAIL mid_rst_q got %b want 00", next_stt_q); end
    n_tests++; if (upd_valid_q !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", upd_valid_q); end
    n_tests++; if (upd_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_upd got %0d want 0", upd_cnt); end
    n_tests++; if (miss_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_miss got %0d want 0", miss_cnt); end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 2'b11);
    tick();
    n_tests++; if (upd_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_release_upd got %0d want 1", upd_cnt); end
    n_tests++; if (next_stt_q !== 2'b10) begin n_fail++; $display("FAIL mid_release_q got %b want 10", next_stt_q); end
    n_tests++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_release_miss got %0d want 1", miss_cnt); end
  endtask

  task automatic test_counter_saturation();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 2'b00);
      tick();
      n_tests++; if (int'(s_upd_cnt) !== m_supd) begin n_fail++; $display("FAIL sat_upd[%0d] got %0d want %0d", i, s_upd_cnt, m_supd); end
      n_tests++; if (int'(s_miss_cnt) !== m_smiss) begin n_fail++; $display("FAIL sat_miss[%0d] got %0d want %0d", i, s_miss_cnt, m_smiss); end
    end
    n_tests++; if (s_upd_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_upd_final got %0d want 7", s_upd_cnt); end
    n_tests++; if (s_miss_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_miss_final got %0d want 7", s_miss_cnt); end
    n_tests++; if (miss_cnt !== 16'd10) begin n_fail++; $display("FAIL sat_wide_miss got %0d want 10", miss_cnt); end
  endtask

  task automatic test_random();
    int s, st, c;
    for (int i = 0; i < 1000; i++) begin
      rst_n = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      st = $urandom_range(0, 3) != 0 ? 1 : 0;
      c  = $urandom_range(0, 1);
      s  = $urandom_range(0, 3);
      drive(st[0], c[0], s[1:0]);
      n_tests++; if (int'(next_stt) !== model_next(s, st, c)) begin n_fail++; $display("FAIL rnd_next[%0d] got %0d want %0d", i, next_stt, model_next(s, st, c)); end
      n_tests++; if (int'(mispredict) !== model_miss(s, st, c)) begin n_fail++; $display("FAIL rnd_miss[%0d] got %b want %0d", i, mispredict, model_miss(s, st, c)); end
      n_tests++; if (int'(pred_dir) !== ((s >= 2) ? 1 : 0)) begin n_fail++; $display("FAIL rnd_pred[%0d] got %b for state %0d", i, pred_dir, s); end
      tick();
      n_tests++; if (int'(next_stt_q) !== m_nq) begin n_fail++; $display("FAIL rnd_next_q[%0d] got %0d want %0d", i, next_stt_q, m_nq); end
      n_tests++; if (int'(upd_valid_q) !== m_vq) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %0d", i, upd_valid_q, m_vq); end
      n_tests++; if (int'(upd_cnt) !== m_upd) begin n_fail++; $display("FAIL rnd_upd[%0d] got %0d want %0d", i, upd_cnt, m_upd); end
      n_tests++; if (int'(miss_cnt) !== m_miss) begin n_fail++; $display("FAIL rnd_misscnt[%0d] got %0d want %0d", i, miss_cnt, m_miss); end
      n_tests++; if (int'(s_upd_cnt) !== m_supd) begin n_fail++; $display("FAIL rnd_s_upd[%0d] got %0d want %0d", i, s_upd_cnt, m_supd); end
      n_tests++; if (int'(s_miss_cnt) !== m_smiss) begin n_fail++; $display("FAIL rnd_s_miss[%0d] got %0d want %0d", i, s_miss_cnt, m_smiss); end
      n_tests++; if (miss_cnt > upd_cnt) begin n_fail++; $display("FAIL rnd_invariant[%0d] miss %0d above upd %0d", i, miss_cnt, upd_cnt); end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_nq = 0; m_vq = 0; m_upd = 0; m_miss = 0; m_supd = 0; m_smiss = 0;
    rst_n = 1'b0; strobe = 1'b0; ctr = 1'b0; crnt_stt = 2'b00;
    test_reset();
    test_saturation_walk();
    test_hold();
    test_mispredict();
    test_reset_mid_stream();
    test_counter_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
